// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-requester data-memory arbiter.
// Widths here set the defaults for the interface and the arbiter top.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W         = 8;
  localparam int unsigned DMEM_DATA_W         = 64;
  localparam int unsigned DMEM_BYTES_PER_WORD = 8;
  localparam int unsigned DMEM_OFF_W          = $clog2(DMEM_BYTES_PER_WORD);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } dmem_state_e;

  // Doubleword accesses must start on an 8-byte boundary.
  function automatic logic dmem_misaligned(input logic [DMEM_ADDR_W-1:0] addr);
    return addr[DMEM_OFF_W-1:0] != '0;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes and data-memory strobes shared by the arbiter, its two
// requesters and the memory.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = dmem_pkg::DMEM_ADDR_W,
  parameter int unsigned DATA_W = dmem_pkg::DMEM_DATA_W
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic              err0, err1;
  logic [DATA_W-1:0] rdata0, rdata1;

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;
  logic              busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, err0, err1, rdata0, rdata1, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rd_data,
    output ack0, ack1, err0, err1, rdata0, rdata1,
    output mem_rd, mem_wr, mem_addr, mem_wr_data, busy
  );

  modport mem (
    input  mem_rd, mem_wr, mem_addr, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/dmem_rr_arb.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to rr_ptr.
module dmem_rr_arb (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       sel,
  output logic       grant_valid
);

  always_comb begin
    grant_valid = |req;
    sel         = (req == 2'b11) ? rr_ptr : req[1];
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU (port 0) and the debug/DMA
// loader (port 1): one doubleword access per grant, all outputs registered.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = DMEM_ADDR_W,
  parameter int unsigned DATA_W      = DMEM_DATA_W,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  dmem_state_e       state_q;
  logic              rr_ptr_q;
  logic              sel_q;
  logic              ack0_q, ack1_q, err0_q, err1_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              mem_rd_q, mem_wr_q, busy_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wr_data_q;

  logic              sel;
  logic              grant_valid;
  logic              gnt_we;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  dmem_rr_arb u_rr_arb (
    .req         ({bus.req1, bus.req0}),
    .rr_ptr      (rr_ptr_q),
    .sel         (sel),
    .grant_valid (grant_valid)
  );

  always_comb begin
    gnt_we    = sel ? bus.we1    : bus.we0;
    gnt_addr  = sel ? bus.addr1  : bus.addr0;
    gnt_wdata = sel ? bus.wdata1 : bus.wdata0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      rr_ptr_q      <= 1'b0;
      sel_q         <= 1'b0;
      ack0_q        <= 1'b0;
      ack1_q        <= 1'b0;
      err0_q        <= 1'b0;
      err1_q        <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      busy_q        <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err0_q <= 1'b0;
      err1_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            sel_q    <= sel;
            rr_ptr_q <= ~sel;
            busy_q   <= 1'b1;
            if (ALIGN_CHECK && dmem_misaligned(gnt_addr)) begin
              // Rejected: answer straight away, memory never strobed.
              state_q <= ST_RESP;
              if (sel) begin
                ack1_q <= 1'b1;
                err1_q <= 1'b1;
              end else begin
                ack0_q <= 1'b1;
                err0_q <= 1'b1;
              end
            end else begin
              state_q    <= ST_ACCESS;
              mem_addr_q <= gnt_addr;
              mem_rd_q   <= ~gnt_we;
              mem_wr_q   <= gnt_we;
              if (gnt_we) mem_wr_data_q <= gnt_wdata;
            end
          end
        end
        ST_ACCESS: begin
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          state_q  <= ST_RESP;
          if (sel_q) ack1_q <= 1'b1;
          else       ack0_q <= 1'b1;
          if (mem_rd_q) begin
            if (sel_q) rdata1_q <= bus.mem_rd_data;
            else       rdata0_q <= bus.mem_rd_data;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ack0        = ack0_q;
  assign bus.ack1        = ack1_q;
  assign bus.err0        = err0_q;
  assign bus.err1        = err1_q;
  assign bus.rdata0      = rdata0_q;
  assign bus.rdata1      = rdata1_q;
  assign bus.mem_rd      = mem_rd_q;
  assign bus.mem_wr      = mem_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a big-endian 256-byte memory model.
module tb_dmem_arbiter;

  localparam logic [63:0] POISON = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(64)) bus ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .ALIGN_CHECK(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory model: doubleword at 8k preloaded with byte 0xkk, k = 0..0xC.
  logic [7:0]  mem [256];
  logic        loaded = 1'b0;
  logic [63:0] rd_word;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int a = 0; a < 256; a++) mem[a] <= (a < 104) ? 8'((a / 8) * 17) : 8'h00;
      loaded <= 1'b1;
    end else if (bus.mem_wr) begin
      for (int i = 0; i < 8; i++) mem[8'(bus.mem_addr + 8'(i))] <= bus.mem_wr_data[63-8*i -: 8];
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) rd_word[63-8*i -: 8] = mem[8'(bus.mem_addr + 8'(i))];
  end

  assign bus.mem_rd_data = bus.mem_rd ? rd_word : POISON;

  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_rd) rd_cnt <= rd_cnt + 1;
    if (bus.mem_wr) wr_cnt <= wr_cnt + 1;
    if (bus.mem_rd && bus.mem_wr) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit p, input bit r, input bit we, input logic [7:0] a,
                       input logic [63:0] wd);
    if (p) begin
      bus.req1 = r; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
    end else begin
      bus.req0 = r; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
    end
  endtask

  // Called on a negedge with the FSM idle; returns on the negedge after the ack.
  task automatic xfer(input string tag, input bit p, input bit we, input logic [7:0] a,
                      input logic [63:0] wd, input int exp_lat);
    int n;
    n = 0;
    drive(p, 1'b1, we, a, wd);
    do begin
      @(negedge clk);
      n++;
    end while (!(p ? bus.ack1 : bus.ack0) && n < 8);
    chk({tag, " latency"}, 64'(n), 64'(exp_lat));
    chk({tag, " other ack"}, 64'(p ? bus.ack0 : bus.ack1), 64'h0);
  endtask

  task automatic release_idle(input string tag, input bit p);
    drive(p, 1'b0, 1'b0, 8'h00, 64'h0);
    @(negedge clk);
    chk({tag, " ack drop"}, 64'(bus.ack0 | bus.ack1), 64'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int          rd0;
  int          wr0;
  int          k;
  int          dual;
  logic [3:0]  order;

  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst ack0", 64'(bus.ack0), 64'h0);
    chk("rst ack1", 64'(bus.ack1), 64'h0);
    chk("rst err0", 64'(bus.err0), 64'h0);
    chk("rst mem_rd", 64'(bus.mem_rd), 64'h0);
    chk("rst mem_wr", 64'(bus.mem_wr), 64'h0);
    chk("rst busy", 64'(bus.busy), 64'h0);
    chk("rst rdata0", bus.rdata0, 64'h0);

    // 1. Single load
    rd0 = rd_cnt;
    xfer("t1 load", 1'b0, 1'b0, 8'h10, 64'h0, 2);
    chk("t1 rdata0", bus.rdata0, 64'h2222_2222_2222_2222);
    chk("t1 err0", 64'(bus.err0), 64'h0);
    chk("t1 busy", 64'(bus.busy), 64'h1);
    release_idle("t1", 1'b0);
    chk("t1 mem_rd cycles", 64'(rd_cnt - rd0), 64'h1);
    chk("t1 busy idle", 64'(bus.busy), 64'h0);

    // 2. Store then load on port 1
    xfer("t2 store", 1'b1, 1'b1, 8'h28, 64'hDEAD_BEEF_0123_4567, 2);
    release_idle("t2 st", 1'b1);
    chk("t2 mem[0x28]", 64'(mem[8'h28]), 64'hDE);
    chk("t2 mem[0x2f]", 64'(mem[8'h2f]), 64'h67);
    xfer("t2 load", 1'b1, 1'b0, 8'h28, 64'h0, 2);
    chk("t2 rdata1", bus.rdata1, 64'hDEAD_BEEF_0123_4567);
    release_idle("t2 ld", 1'b1);

    // 3. Continuous contention from reset
    do_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 64'h0);
    drive(1'b1, 1'b1, 1'b0, 8'h08, 64'h0);
    k = 0;
    dual = 0;
    order = 4'hF;
    for (int c = 0; c < 30 && k < 4; c++) begin
      @(negedge clk);
      if (bus.ack0 && bus.ack1) dual++;
      else if (bus.ack0) begin order[k] = 1'b0; k++; end
      else if (bus.ack1) begin order[k] = 1'b1; k++; end
    end
    chk("t3 ack count", 64'(k), 64'h4);
    chk("t3 ack order", 64'(order), 64'hA);
    chk("t3 dual acks", 64'(dual), 64'h0);
    chk("t3 rdata0", bus.rdata0, 64'h0);
    chk("t3 rdata1", bus.rdata1, 64'h1111_1111_1111_1111);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    release_idle("t3", 1'b1);

    // 4. Misaligned load rejected
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    xfer("t4 misaligned", 1'b0, 1'b0, 8'h13, 64'h0, 1);
    chk("t4 err0", 64'(bus.err0), 64'h1);
    chk("t4 err1", 64'(bus.err1), 64'h0);
    release_idle("t4", 1'b0);
    chk("t4 no mem strobes", 64'((rd_cnt - rd0) + (wr_cnt - wr0)), 64'h0);

    // 5. Reset during ACCESS of a port-1 load
    drive(1'b1, 1'b1, 1'b0, 8'h30, 64'h0);
    @(negedge clk);
    chk("t5 in access", 64'(bus.mem_rd), 64'h1);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 64'h0);
    rst = 1'b0;
    chk("t5 ack1", 64'(bus.ack1), 64'h0);
    chk("t5 mem_rd", 64'(bus.mem_rd), 64'h0);
    chk("t5 busy", 64'(bus.busy), 64'h0);
    chk("t5 mem_addr", 64'(bus.mem_addr), 64'h0);
    chk("t5 mem_wr_data", bus.mem_wr_data, 64'h0);
    chk("t5 rdata1", bus.rdata1, 64'h0);
    @(negedge clk);
    chk("t5 no late ack", 64'(bus.ack1), 64'h0);
    xfer("t5 rereq", 1'b1, 1'b0, 8'h30, 64'h0, 2);
    chk("t5 rdata1 reload", bus.rdata1, 64'h6666_6666_6666_6666);
    release_idle("t5", 1'b1);

    // 6. Last legal doubleword
    xfer("t6 store", 1'b0, 1'b1, 8'hF8, 64'h0102_0304_0506_0708, 2);
    release_idle("t6 st", 1'b0);
    chk("t6 mem[0xff]", 64'(mem[8'hFF]), 64'h08);
    xfer("t6 load", 1'b0, 1'b0, 8'hF8, 64'h0, 2);
    chk("t6 rdata0", bus.rdata0, 64'h0102_0304_0506_0708);
    release_idle("t6 ld", 1'b0);

    chk("rd/wr never together", 64'(both_cnt), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester controller that shares the single-port, byte-addressed 256-byte data memory.
- Requester 0 is the CPU load/store path; requester 1 is the debug/DMA loader.
- Arbitrates round-robin, checks alignment, sequences one 64-bit access per grant and returns read data with a one-cycle ack.
- Sits between the requesters and the data memory's clk/mem_wr/mem_rd/addr/wr_data/rd_data interface.

Parameters:
- ADDR_W, 8, byte address width into data memory.
- DATA_W, 64, access width (doubleword, big-endian byte order, handled by memory).
- ALIGN_CHECK, 1, when 1 reject addresses with addr[2:0] != 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0 / req1  in  1  access request, held high until matching ack.
- we0 / we1  in  1  1 = store, 0 = load; valid while req high.
- addr0 / addr1  in  ADDR_W  byte address; valid while req high.
- wdata0 / wdata1  in  DATA_W  store data; valid while req high.
- ack0 / ack1  out  1  one-cycle completion pulse.
- err0 / err1  out  1  with ack: access rejected (misaligned), memory untouched.
- rdata0 / rdata1  out  DATA_W  load data, valid with ack, held until next ack to that port.
- mem_rd  out  1  to memory read enable.
- mem_wr  out  1  to memory write enable.
- mem_addr  out  ADDR_W  to memory address.
- mem_wr_data  out  DATA_W  to memory write data.
- mem_rd_data  in  DATA_W  from memory (combinational, Z when mem_rd=0).
- busy  out  1  high in ACCESS or RESP.

Behaviour:
- Reset values: state=IDLE; rr_ptr=0 (requester 0 favoured first); ack*, err*, mem_rd, mem_wr, busy = 0; mem_addr=0; mem_wr_data=0; rdata* = 0.
- All outputs are registered.
- FSM states: IDLE, ACCESS, RESP.
- IDLE, arbitration:
  - Only one request: grant it.
  - Both requesting: grant rr_ptr side.
  - On grant: latch sel, we, addr, wdata; rr_ptr <= ~sel.
  - Misaligned with ALIGN_CHECK=1: go to RESP with err flag; no mem strobes.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - Load: mem_rd=1, mem_wr=0, mem_addr=latched addr; mem_rd_data captured into the selected rdata at the closing edge.
  - Store: mem_rd=0, mem_wr=1, mem_wr_data=latched wdata; memory commits at the closing edge.
  - Never assert mem_rd and mem_wr together.
  - Go to RESP.
- RESP:
  - ack[sel]=1 for one cycle; err[sel] set only for rejected accesses; the other port's ack stays 0.
  - Go to IDLE.
- Latency:
  - Req sampled at edge N gives ack high in cycle N+2 (rejected: N+1).
  - Per-requester throughput is one access per 3 cycles.
  - Back-to-back: a requester keeping req high after ack is re-arbitrated in the next IDLE.
- Requester rules:
  - May not change we/addr/wdata while req high and before ack.
  - Dropping req before ack is illegal; the latched access still completes and acks.
- Simultaneous requests: strict alternation under continuous contention; no starvation.
- Address wrap: addr=0xF8 is the last legal doubleword; higher aligned addresses are impossible with ADDR_W=8.
- Reset mid-operation:
  - rst during ACCESS: a store strobe sampled at that same edge may commit; no ack is issued.
  - FSM returns to IDLE and the pending requester must re-request.
- Outside ACCESS, mem_rd=0 and mem_rd_data is ignored (Z tolerated).

Decomposition:
- Shared package dmem_pkg:
  - State enum ST_IDLE/ST_ACCESS/ST_RESP.
  - DMEM_ADDR_W=8, DMEM_DATA_W=64, DMEM_BYTES_PER_WORD=8.
- One sub-module: dmem_rr_arb (2-way round-robin pick, inputs req[1:0] and rr_ptr, output sel and grant_valid, purely combinational).
- FSM, latches and memory strobes stay in dmem_arbiter.

Test Plan:
Bench preload: doubleword at byte 8k holds byte value 0xkk repeated, k=0..0xC.
1. Single load: req0, we0=0, addr0=0x10 -> ack0 at req+2 cycles, rdata0=0x2222222222222222, err0=0, mem_rd high exactly 1 cycle.
2. Store-then-load: req1 store 0xDEADBEEF01234567 to 0x28, then load 0x28 -> second ack1 rdata1=0xDEADBEEF01234567; memory byte 0x28 = 0xDE.
3. Contention: req0 and req1 both held continuously, loads of 0x00 and 0x08 -> acks alternate 0,1,0,1 starting with 0 after reset, rdata0=0, rdata1=0x1111111111111111.
4. Misaligned: req0 load addr0=0x13 -> ack0 and err0 one cycle after sample, mem_rd/mem_wr never asserted.
5. Reset mid-access: assert rst during ACCESS of a req1 load from 0x30 -> no ack1; all outputs at reset values next cycle; after re-request, rdata1=0x6666666666666666.
6. Boundary address: load 0xF8 after store of 0x0102030405060708 -> rdata=0x0102030405060708, no X on rdata.
